// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserialiser with valid/ready output register.
// Collects WIDTH bits qualified by s_valid into a word (LSB- or MSB-first), supports a
// synchronous frame abort (clr), sticky overrun detection and optional parity checking.
// Optional feature macro: SIPO_PARITY_EN (frame = WIDTH data bits + 1 parity bit).
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   s_in     serial data bit
//   s_valid  s_in accepted on this edge
//   clr      synchronous abort of the partial word
//   p_ready  consumer accepts p_data
//   p_data   assembled word (registered)
//   p_valid  p_data holds an unconsumed word
//   bit_cnt  bits held in the current partial frame
//   overrun  sticky: a completed word was dropped
//   par_err  parity error for the word in p_data (0 when parity disabled)
module sipo_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned ODD_PAR   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_in,
  input  logic                           s_valid,
  input  logic                           clr,
  input  logic                           p_ready,
  output logic [WIDTH-1:0]               p_data,
  output logic                           p_valid,
  output logic [$clog2(WIDTH+2)-1:0]     bit_cnt,
  output logic                           overrun,
  output logic                           par_err
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef SIPO_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shift_c;
  logic [WIDTH-1:0] word_c;
  logic             is_data_c;
  logic             par_c;
  logic             last_c;
  logic             done_c;

  // Next shift-register value for an accepted data bit
  always_comb begin
    sh_shift_c = sh;
    if (LSB_FIRST != 0) sh_shift_c = {s_in, sh[WIDTH-1:1]};
    else                sh_shift_c = {sh[WIDTH-2:0], s_in};
  end

`ifdef SIPO_PARITY_EN
  // Final bit of the frame is parity: data is already complete in sh
  assign is_data_c = (bit_cnt < CW'(WIDTH));
  assign word_c    = sh;
  assign par_c     = ((^sh) ^ s_in) != 1'(ODD_PAR);
`else
  logic unused_par_sense;
  assign unused_par_sense = 1'(ODD_PAR);
  assign is_data_c = 1'b1;
  assign word_c    = sh_shift_c;
  assign par_c     = 1'b0;
`endif

  assign last_c = (bit_cnt == CW'(FL - 1));
  assign done_c = s_valid && !clr && last_c;

  // Frame assembly and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      sh      <= '0;
      bit_cnt <= '0;
      p_data  <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (clr) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else if (s_valid) begin
        if (is_data_c) sh <= sh_shift_c;
        bit_cnt <= last_c ? '0 : bit_cnt + CW'(1);
      end

      // A completing word may only land if the output slot is free or draining now
      if (done_c) begin
        if (!p_valid || p_ready) begin
          p_data  <= word_c;
          par_err <= par_c;
          p_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule
